// File: rtl/opb_register_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : opb_register_bank_pkg
//  Purpose  : Shared definitions for the OPB register bank: transfer FSM
//             state encoding, OPB <-> little-endian bit reordering and the
//             register-index width helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package opb_register_bank_pkg;

   // Two-state transfer FSM: wait for a hit, then a single acknowledge cycle.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } opb_state_t;

   localparam int C_REG_BYTES = 4;

   // OPB numbers bit 0 as the MSB; user-side words number bit 31 as the MSB.
   function automatic logic [0:31] opb_swap32(input logic [31:0] v);
      logic [0:31] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // Width of the register index; at least one bit so a single-register
   // bank still has a legal select vector.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : opb_register_bank_pkg
`default_nettype wire

// File: rtl/opb_reg_slice.sv
`default_nettype none
// ============================================================================
//  Module   : opb_reg_slice
//  Purpose  : One 32-bit byte-enabled user register with write strobe and
//             optional self-clear.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             i_we          - commit a write at this edge
//             i_be[3:0]     - byte enables, bit b covers bits 8b+7:8b
//             i_wdata[31:0] - write data
//             o_q[31:0]     - register value
//             o_strobe      - one-cycle pulse, concurrent with the new value
//  Revision : 1.0 - initial release
// ============================================================================
module opb_reg_slice
   import opb_register_bank_pkg::*;
#(
   parameter bit SELF_CLEAR = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_we,
   input  logic [3:0]  i_be,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_q,
   output logic        o_strobe
);

   logic [31:0] r_q;
   logic        r_strobe;
   logic [31:0] w_merged;

   generate
      for (genvar b = 0; b < C_REG_BYTES; b++) begin : g_byte
         assign w_merged[8*b +: 8] = i_be[b] ? i_wdata[8*b +: 8] : r_q[8*b +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q      <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_strobe <= i_we;
         if (i_we) begin
            r_q <= w_merged;
         end else if (SELF_CLEAR && r_strobe) begin
            // Written value lives only for the strobe cycle.
            r_q <= '0;
         end
      end
   end

   assign o_q      = r_q;
   assign o_strobe = r_strobe;

endmodule : opb_reg_slice
`default_nettype wire

// File: rtl/opb_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : opb_register_bank
//  Purpose  : OPB slave exposing C_NUM_REGS 32-bit registers. Each register
//             is either writable (optionally self-clearing) or a read-only
//             status word taken from user_data_in.
//  Ports    : OPB_Clk, OPB_Rst           - clock, synchronous reset
//             OPB_ABus/BE/DBus/RNW/select/seqAddr - OPB slave inputs
//             Sl_DBus/xferAck/errAck/retry/toutSup - OPB slave outputs
//             user_data_out   - register i on bits [32i+31:32i]
//             user_data_in    - status words for read-only registers
//             user_wr_strobe  - one-cycle pulse per accepted write
//  Revision : 1.0 - initial release
// ============================================================================
module opb_register_bank
   import opb_register_bank_pkg::*;
#(
   parameter logic [31:0]           C_BASEADDR   = 32'h01003700,
   parameter logic [31:0]           C_HIGHADDR   = 32'h010037FF,
   parameter int                    C_OPB_AWIDTH = 32,
   parameter int                    C_OPB_DWIDTH = 32,
   parameter int                    C_NUM_REGS   = 4,
   parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0,
   parameter logic [C_NUM_REGS-1:0] C_SC_MASK    = '0,
   parameter string                 C_FAMILY     = "virtex5"
) (
   input  logic                       OPB_Clk,
   input  logic                       OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
   input  logic [0:3]                 OPB_BE,
   input  logic [0:31]                OPB_DBus,
   input  logic                       OPB_RNW,
   input  logic                       OPB_select,
   input  logic                       OPB_seqAddr,
   output logic [0:31]                Sl_DBus,
   output logic                       Sl_xferAck,
   output logic                       Sl_errAck,
   output logic                       Sl_retry,
   output logic                       Sl_toutSup,
   output logic [C_NUM_REGS*32-1:0]   user_data_out,
   input  logic [C_NUM_REGS*32-1:0]   user_data_in,
   output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

   localparam int C_IW = idx_width(C_NUM_REGS);
   localparam int C_AW = C_OPB_AWIDTH;

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [C_AW-1:0] w_abus;
   logic [C_AW-1:0] w_offset;
   logic            w_hit;
   logic            w_idx_ok;
   logic [C_IW-1:0] w_idx;
   logic            w_unused_ok;

   assign w_abus   = OPB_ABus;
   assign w_offset = w_abus - C_BASEADDR[C_AW-1:0];
   assign w_hit    = OPB_select
                   && (w_abus >= C_BASEADDR[C_AW-1:0])
                   && (w_abus <= C_HIGHADDR[C_AW-1:0]);
   // Full word offset is compared so addresses beyond the last register
   // but inside the window are recognised rather than aliased.
   assign w_idx_ok = ({2'b00, w_offset[C_AW-1:2]} < C_AW'(C_NUM_REGS));
   assign w_idx    = w_offset[C_IW+1:2];

   // Sequential-address hint and byte offset carry no meaning here.
   assign w_unused_ok = &{1'b0, OPB_seqAddr, w_offset[1:0]};

   // ---------------------------------------------------------------------
   // Read mux: read-only registers show the live status word
   // ---------------------------------------------------------------------
   logic [31:0] w_q        [C_NUM_REGS];
   logic [31:0] w_rd_words [C_NUM_REGS];
   logic [31:0] w_rd_word;

   generate
      for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_rdmux
         assign w_rd_words[i] = C_RO_MASK[i] ? user_data_in[32*i +: 32] : w_q[i];
      end
   endgenerate

   assign w_rd_word = w_idx_ok ? w_rd_words[w_idx] : 32'h0;

   // ---------------------------------------------------------------------
   // Transfer FSM with registered OPB outputs
   // ---------------------------------------------------------------------
   opb_state_t      r_state;
   logic            r_xfer_ack;
   logic [0:31]     r_dbus;
   logic            r_rnw;
   logic            r_idx_ok;
   logic [C_IW-1:0] r_idx;
   logic [31:0]     r_wdata;
   logic [3:0]      r_be;

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         r_state    <= ST_IDLE;
         r_xfer_ack <= 1'b0;
         r_dbus     <= '0;
         r_rnw      <= 1'b1;
         r_idx_ok   <= 1'b0;
         r_idx      <= '0;
         r_wdata    <= '0;
         r_be       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_state    <= ST_ACK;
                  r_xfer_ack <= 1'b1;
                  r_dbus     <= OPB_RNW ? opb_swap32(w_rd_word) : '0;
                  r_rnw      <= OPB_RNW;
                  r_idx_ok   <= w_idx_ok;
                  r_idx      <= w_idx;
                  r_wdata    <= OPB_DBus;
                  r_be       <= OPB_BE;
               end
            end
            ST_ACK: begin
               // Selection is not re-examined here, so a held select
               // produces exactly one ack per two cycles.
               r_state    <= ST_IDLE;
               r_xfer_ack <= 1'b0;
               r_dbus     <= '0;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_xfer_ack <= 1'b0;
               r_dbus     <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Register slices; the commit happens at the edge closing the ACK cycle,
   // where the slice's own reset takes priority and aborts the write.
   // ---------------------------------------------------------------------
   generate
      for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
         logic w_we;

         assign w_we = (r_state == ST_ACK) && !r_rnw && r_idx_ok
                    && (r_idx == C_IW'(i)) && !C_RO_MASK[i] && (|r_be);

         opb_reg_slice #(
            .SELF_CLEAR (C_SC_MASK[i])
         ) u_slice (
            .clk      (OPB_Clk),
            .rst      (OPB_Rst),
            .i_we     (w_we),
            .i_be     (r_be),
            .i_wdata  (r_wdata),
            .o_q      (w_q[i]),
            .o_strobe (user_wr_strobe[i])
         );

         assign user_data_out[32*i +: 32] = w_q[i];
      end
   endgenerate

   assign Sl_DBus    = r_dbus;
   assign Sl_xferAck = r_xfer_ack;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

endmodule : opb_register_bank
`default_nettype wire

// File: tb/tb_opb_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_opb_register_bank
//  Purpose  : Directed self-checking bench for opb_register_bank. A second
//             instance with a self-clearing register 0 shares the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_opb_register_bank;

   localparam logic [31:0] BASE = 32'h01003700;
   localparam logic [31:0] HIGH = 32'h010037FF;

   logic          clk;
   logic          rst;
   logic [0:31]   abus;
   logic [0:3]    be;
   logic [0:31]   dbus_in;
   logic          rnw;
   logic          sel;
   logic          seq;
   logic [127:0]  udi;

   logic [0:31]   dbus;
   logic          ack, err_ack, retry, tout;
   logic [127:0]  udo;
   logic [3:0]    strobe;

   logic [0:31]   sc_dbus;
   logic          sc_ack, sc_err_ack, sc_retry, sc_tout;
   logic [127:0]  sc_udo;
   logic [3:0]    sc_strobe;

   int n_tests = 0;
   int n_fail  = 0;

   opb_register_bank #(
      .C_NUM_REGS (4),
      .C_RO_MASK  (4'b0100),
      .C_SC_MASK  (4'b0000)
   ) dut (
      .OPB_Clk        (clk),
      .OPB_Rst        (rst),
      .OPB_ABus       (abus),
      .OPB_BE         (be),
      .OPB_DBus       (dbus_in),
      .OPB_RNW        (rnw),
      .OPB_select     (sel),
      .OPB_seqAddr    (seq),
      .Sl_DBus        (dbus),
      .Sl_xferAck     (ack),
      .Sl_errAck      (err_ack),
      .Sl_retry       (retry),
      .Sl_toutSup     (tout),
      .user_data_out  (udo),
      .user_data_in   (udi),
      .user_wr_strobe (strobe)
   );

   opb_register_bank #(
      .C_NUM_REGS (4),
      .C_RO_MASK  (4'b0000),
      .C_SC_MASK  (4'b0001)
   ) dut_sc (
      .OPB_Clk        (clk),
      .OPB_Rst        (rst),
      .OPB_ABus       (abus),
      .OPB_BE         (be),
      .OPB_DBus       (dbus_in),
      .OPB_RNW        (rnw),
      .OPB_select     (sel),
      .OPB_seqAddr    (seq),
      .Sl_DBus        (sc_dbus),
      .Sl_xferAck     (sc_ack),
      .Sl_errAck      (sc_err_ack),
      .Sl_retry       (sc_retry),
      .Sl_toutSup     (sc_tout),
      .user_data_out  (sc_udo),
      .user_data_in   (udi),
      .user_wr_strobe (sc_strobe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic r, input logic [31:0] d,
                        input logic [3:0] b);
      abus    = a;
      rnw     = r;
      dbus_in = d;
      be      = b;
      sel     = 1'b1;
   endtask

   task automatic bus_idle();
      sel     = 1'b0;
      abus    = '0;
      dbus_in = '0;
      be      = '0;
      rnw     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b0 || dbus !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus: ack=%b dbus=%h required ack=0 dbus=0", ack, dbus);
      end
      n_tests++;
      if (udo !== 128'h0 || strobe !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_user: udo=%h strobe=%b required 0", udo, strobe);
      end
      n_tests++;
      if ({err_ack, retry, tout} !== 3'b000) begin
         n_fail++;
         $display("FAIL const_outputs: got %b required 000", {err_ack, retry, tout});
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_write_full();
      drive(BASE + 32'd4, 1'b0, 32'hDEADBEEF, 4'b1111);
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_in_hit_cycle: got %b required 0", ack);
      end
      tick();
      bus_idle();
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b1 || dbus !== 32'h0) begin
         n_fail++;
         $display("FAIL write_ack: ack=%b dbus=%h required ack=1 dbus=0", ack, dbus);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (udo[63:32] !== 32'hDEADBEEF || strobe !== 4'b0010 || ack !== 1'b0) begin
         n_fail++;
         $display("FAIL write_full: reg1=%h strobe=%b ack=%b required DEADBEEF 0010 0",
                  udo[63:32], strobe, ack);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (strobe !== 4'b0000) begin
         n_fail++;
         $display("FAIL strobe_width: got %b required 0000", strobe);
      end
      tick();
   endtask

   task automatic test_byte_write();
      drive(BASE, 1'b0, 32'hAABBCCDD, 4'b1111);
      tick();
      bus_idle();
      tick();
      tick();
      drive(BASE, 1'b0, 32'h11223344, 4'b0100);
      tick();
      bus_idle();
      tick();
      @(negedge clk);
      n_tests++;
      if (udo[31:0] !== 32'hAA22CCDD || strobe !== 4'b0001) begin
         n_fail++;
         $display("FAIL byte_write: reg0=%h strobe=%b required AA22CCDD 0001",
                  udo[31:0], strobe);
      end
      tick();
      drive(BASE, 1'b1, 32'h0, 4'b1111);
      @(negedge clk);
      n_tests++;
      if (dbus !== 32'h0) begin
         n_fail++;
         $display("FAIL dbus_before_ack: got %h required 0", dbus);
      end
      tick();
      bus_idle();
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b1 || dbus !== 32'hAA22CCDD) begin
         n_fail++;
         $display("FAIL readback: ack=%b dbus=%h required 1 AA22CCDD", ack, dbus);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b0 || dbus !== 32'h0) begin
         n_fail++;
         $display("FAIL dbus_after_ack: ack=%b dbus=%h required 0 0", ack, dbus);
      end
      tick();
   endtask

   task automatic test_self_clear();
      drive(BASE, 1'b0, 32'h00000001, 4'b1111);
      tick();
      bus_idle();
      tick();
      @(negedge clk);
      n_tests++;
      if (sc_udo[31:0] !== 32'h1 || sc_strobe !== 4'b0001) begin
         n_fail++;
         $display("FAIL self_clear_hold: reg0=%h strobe=%b required 1 0001",
                  sc_udo[31:0], sc_strobe);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (sc_udo[31:0] !== 32'h0 || sc_strobe !== 4'b0000) begin
         n_fail++;
         $display("FAIL self_clear_drop: reg0=%h strobe=%b required 0 0000",
                  sc_udo[31:0], sc_strobe);
      end
      tick();
   endtask

   task automatic test_read_only();
      udi[95:64] = 32'h12345678;
      drive(BASE + 32'd8, 1'b1, 32'h0, 4'b1111);
      tick();
      bus_idle();
      udi[95:64] = 32'hCAFEF00D;
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b1 || dbus !== 32'h12345678) begin
         n_fail++;
         $display("FAIL ro_read: ack=%b dbus=%h required 1 12345678", ack, dbus);
      end
      tick();
      drive(BASE + 32'd8, 1'b0, 32'hFFFFFFFF, 4'b1111);
      tick();
      bus_idle();
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b1) begin
         n_fail++;
         $display("FAIL ro_write_ack: got %b required 1", ack);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (strobe !== 4'b0000 || udo[95:64] !== 32'h0) begin
         n_fail++;
         $display("FAIL ro_write_discard: strobe=%b reg2=%h required 0000 0",
                  strobe, udo[95:64]);
      end
      tick();
      drive(BASE + 32'd8, 1'b1, 32'h0, 4'b1111);
      tick();
      bus_idle();
      @(negedge clk);
      n_tests++;
      if (dbus !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL ro_live: dbus=%h required CAFEF00D", dbus);
      end
      tick();
   endtask

   task automatic test_out_of_range();
      int acks = 0;
      int strobes = 0;
      drive(HIGH + 32'd4, 1'b0, 32'hFFFFFFFF, 4'b1111);
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (ack === 1'b1) acks++;
         if (strobe !== 4'b0000) strobes++;
         tick();
      end
      drive(BASE - 32'd4, 1'b0, 32'hFFFFFFFF, 4'b1111);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ack === 1'b1) acks++;
         if (strobe !== 4'b0000) strobes++;
         tick();
      end
      bus_idle();
      @(negedge clk);
      n_tests++;
      if (acks != 0 || strobes != 0) begin
         n_fail++;
         $display("FAIL miss_no_ack: acks=%0d strobes=%0d required 0 0", acks, strobes);
      end
      n_tests++;
      if (udo !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h00000001}) begin
         n_fail++;
         $display("FAIL miss_no_change: udo=%h required 0000000000000000DEADBEEF00000001", udo);
      end
      tick();
      drive(BASE + 32'd60, 1'b1, 32'h0, 4'b1111);
      tick();
      bus_idle();
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b1 || dbus !== 32'h0) begin
         n_fail++;
         $display("FAIL idx15_read: ack=%b dbus=%h required 1 0", ack, dbus);
      end
      tick();
      drive(BASE + 32'd60, 1'b0, 32'hFFFFFFFF, 4'b1111);
      tick();
      bus_idle();
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b1) begin
         n_fail++;
         $display("FAIL idx15_write_ack: got %b required 1", ack);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (strobe !== 4'b0000 || udo !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h00000001}) begin
         n_fail++;
         $display("FAIL idx15_write_discard: strobe=%b udo=%h", strobe, udo);
      end
      tick();
   endtask

   task automatic test_reset_in_ack();
      drive(BASE + 32'd12, 1'b0, 32'hFFFFFFFF, 4'b1111);
      tick();
      bus_idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (ack !== 1'b0 || dbus !== 32'h0 || udo !== 128'h0 || strobe !== 4'b0) begin
         n_fail++;
         $display("FAIL reset_in_ack: ack=%b dbus=%h udo=%h strobe=%b required all 0",
                  ack, dbus, udo, strobe);
      end
      tick();
      @(negedge clk);
      n_tests++;
      if (strobe !== 4'b0 || udo[127:96] !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_abort_late: strobe=%b reg3=%h required 0 0", strobe, udo[127:96]);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] ack_pat;
      logic [31:0] rd4;
      int n_strobe;
      drive(BASE + 32'd4, 1'b0, 32'h0BADF00D, 4'b1111);
      tick();
      bus_idle();
      tick();
      tick();
      ack_pat = '0;
      rd4 = '0;
      drive(BASE + 32'd4, 1'b1, 32'h0, 4'b1111);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         ack_pat[c] = ack;
         if (c == 3) rd4 = dbus;
         tick();
      end
      bus_idle();
      n_tests++;
      if (ack_pat !== 4'b1010) begin
         n_fail++;
         $display("FAIL b2b_read_acks: cycles1..4 (lsb first)=%b required 1010", ack_pat);
      end
      n_tests++;
      if (rd4 !== 32'h0BADF00D) begin
         n_fail++;
         $display("FAIL b2b_read_data: got %h required 0BADF00D", rd4);
      end
      tick();
      n_strobe = 0;
      drive(BASE, 1'b0, 32'h00000055, 4'b1111);
      for (int c = 0; c < 6; c++) begin
         if (c == 4) bus_idle();
         @(negedge clk);
         if (strobe[0] === 1'b1) n_strobe++;
         tick();
      end
      n_tests++;
      if (n_strobe != 2 || udo[31:0] !== 32'h55) begin
         n_fail++;
         $display("FAIL b2b_write: strobes=%0d reg0=%h required 2 00000055", n_strobe, udo[31:0]);
      end
   endtask

   initial begin
      rst = 1'b1;
      seq = 1'b0;
      udi = '0;
      bus_idle();
      test_reset();
      test_write_full();
      test_byte_write();
      test_self_clear();
      test_read_only();
      test_out_of_range();
      test_reset_in_ack();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_opb_register_bank
`default_nettype wire

// File: doc/opb_register_bank.md
OPB_REGISTER_BANK -- requirements
Module: opb_register_bank

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01003700, first byte address of the window.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010037FF, last byte address of the window.
REQ-003 SHALL have parameter C_OPB_AWIDTH, default 32, address width; C_OPB_DWIDTH, default 32, data width (only 32 supported).
REQ-004 SHALL have parameter C_NUM_REGS, default 4, legal range 1..16, number of 32-bit registers.
REQ-005 SHALL have parameter C_RO_MASK, default 0, width C_NUM_REGS; bit i set = register i is read-only status.
REQ-006 SHALL have parameter C_SC_MASK, default 0, width C_NUM_REGS; bit i set = register i self-clears.
REQ-007 SHALL have parameter C_FAMILY, default "virtex5", informational only.
REQ-008 OPB_Clk  in  1  sole clock; all logic rising-edge.
REQ-009 OPB_Rst  in  1  synchronous, active-high reset.
REQ-010 OPB_ABus in [0:31], OPB_BE in [0:3], OPB_DBus in [0:31], OPB_RNW in 1, OPB_select in 1, OPB_seqAddr in 1 (ignored): OPB slave inputs.
REQ-011 Sl_DBus out [0:31], Sl_xferAck out 1, Sl_errAck / Sl_retry / Sl_toutSup out 1 each: OPB slave outputs.
REQ-012 user_data_out  out  [C_NUM_REGS*32-1:0]  register i on bits [32i+31:32i].
REQ-013 user_data_in  in  [C_NUM_REGS*32-1:0]  status words; slice i used only when C_RO_MASK[i]=1.
REQ-014 user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse per accepted write to writable register i.

Function
REQ-015 Hit = OPB_select & C_BASEADDR <= OPB_ABus <= C_HIGHADDR; index = OPB_ABus[word address bits], i.e. (ABus - C_BASEADDR) >> 2.
REQ-016 FSM states IDLE, ACK: IDLE->ACK on hit; ACK->IDLE unconditionally.
REQ-017 Sl_xferAck SHALL be 1 exactly in the ACK state: one cycle, in cycle N+1 when the hit is sampled in cycle N.
REQ-018 Back-to-back transfers (select held high) SHALL be acked every second cycle; no double ack per transfer.
REQ-019 Sl_DBus SHALL be 0 except in ACK for a read, when it carries the addressed word (bit-reversed: OPB bit 0 = user bit 31).
REQ-020 Read of writable reg returns current register value; read of RO reg returns user_data_in slice sampled in the hit cycle.
REQ-021 Write (RNW=0) SHALL update the register at the edge ending the ACK cycle, per byte: OPB_BE[0] enables user bits 31:24 ... BE[3] bits 7:0; data captured in the hit cycle.
REQ-022 user_wr_strobe[i] SHALL pulse in the cycle after ACK, concurrent with the new user_data_out value, for any write with at least one BE set.
REQ-023 Self-clear reg: value held for exactly one cycle (the strobe cycle), then returns to 0.
REQ-024 Writes to RO regs or to index >= C_NUM_REGS SHALL be acked, discarded, no strobe; reads of index >= C_NUM_REGS SHALL return 0.
REQ-025 Sl_errAck, Sl_retry, Sl_toutSup SHALL be constant 0.
REQ-026 Miss (address out of window) SHALL produce no ack and no state change.

Reset
REQ-027 OPB_Rst SHALL force FSM to IDLE, all registers to 0, Sl_xferAck 0, Sl_DBus 0, user_wr_strobe 0 at the next edge.
REQ-028 Reset asserted during ACK SHALL abort the transfer: no register update, no strobe.

Structure
REQ-029 Shared package SHALL hold FSM state encoding, OPB bit-reverse function and index-width function (clog2 of C_NUM_REGS).
REQ-030 One sub-module opb_reg_slice (32-bit byte-enabled register with self-clear and strobe) SHALL be instantiated per register via generate.

Verification
REQ-031 Write 0xDEADBEEF, BE=1111, to C_BASEADDR+4 -> xferAck one cycle after select; user_data_out[63:32]=0xDEADBEEF and user_wr_strobe=0010 in the following cycle.
REQ-032 Write 0x11223344, BE=0100, to reg 0 holding 0xAABBCCDD -> reg 0 = 0xAA22CCDD; readback returns 0xAA22CCDD on Sl_DBus during ack only.
REQ-033 C_SC_MASK=0001, write 0x1 to reg 0 -> user_data_out[31:0]=1 for exactly one cycle, then 0.
REQ-034 C_RO_MASK=0100, user_data_in[95:64]=0x12345678; read reg 2 -> 0x12345678; write reg 2 -> ack, no strobe, value unchanged.
REQ-035 Address C_HIGHADDR+4 with select -> no ack for 16 cycles; address of index 15 with C_NUM_REGS=4 -> ack, read 0.
REQ-036 OPB_Rst asserted in ACK cycle of a write of 0xFFFFFFFF -> all outputs 0 next cycle, no strobe; select held high twice back-to-back -> acks in cycles 2 and 4.
